// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for the 5-stage core. It resolves three kinds of
// hazard and turns them into datapath controls:
//   * RAW hazards on execute-stage sources, resolved by forwarding from the
//     memory or writeback stage (memory stage wins, x0 is never forwarded).
//   * Load-use hazards, resolved by stalling F/D for one cycle and bubbling E.
//   * Taken branches/jumps in execute, resolved by flushing D and E.
// Multi-cycle execute operations (mul/div/CSR) are sequenced by a small
// IDLE/BUSY FSM that holds F/D/E until the unit reports done or a timeout
// forces the pipeline to move on.
//
// Parameters
//   RD_SRC_MEM   rd_write_src encoding meaning "rd loaded from data memory"
//   MC_TIMEOUT   max BUSY cycles before forced release (>= 2)
//   CNT_W        width of the stall performance counter
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   rs1_d, rs2_d                 sources of the instruction in decode
//   rs1_e, rs2_e, rd_e           sources / destination in execute
//   rd_write_e, rd_write_src_e   execute writes rd, and from where
//   pc_write_e                   execute redirects the PC
//   mc_start_e, mc_done          multi-cycle op present / result valid pulse
//   rd_m, rd_write_m             memory-stage destination and write enable
//   rd_w, rd_write_w             writeback-stage destination and write enable
//   forwarding_rs1_e/rs2_e       00 regfile, 01 rd_data_w, 10 alu_res_m
//   stall_f, stall_d, stall_e    hold fetch / decode / execute registers
//   flush_d, flush_e             bubble decode / execute registers
//   mc_busy, mc_timeout          FSM in BUSY / one-cycle forced-release pulse
//   stall_cycles                 wrapping count of cycles with stall_f = 1
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter logic [1:0] RD_SRC_MEM = 2'b01,
    parameter int         MC_TIMEOUT = 64,
    parameter int         CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             rd_write_e,
    input  logic [1:0]       rd_write_src_e,
    input  logic             pc_write_e,
    input  logic             mc_start_e,
    input  logic             mc_done,
    input  logic [4:0]       rd_m,
    input  logic [4:0]       rd_w,
    input  logic             rd_write_m,
    input  logic             rd_write_w,
    output logic [1:0]       forwarding_rs1_e,
    output logic [1:0]       forwarding_rs2_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             flush_d,
    output logic             flush_e,
    output logic             mc_busy,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

    // The busy counter only has to reach MC_TIMEOUT-1.
    localparam int              BSY_W    = $clog2(MC_TIMEOUT);
    localparam logic [BSY_W-1:0] BSY_LAST = BSY_W'(MC_TIMEOUT - 1);

    mc_state_t        state_q, state_d;
    logic [BSY_W-1:0] bsy_cnt_q, bsy_cnt_d;
    logic             mc_timeout_q, mc_timeout_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic mc_hold;
    logic load_use;
    logic [1:0] fwd_rs1, fwd_rs2;

    // Multi-cycle sequencer next-state logic. mc_hold is asserted only while
    // the op is genuinely still outstanding: a zero-latency op (start and done
    // together in IDLE) never holds, and the cycle that sees mc_done or the
    // last allowed busy count releases the pipeline on its closing edge.
    always_comb begin
        state_d      = state_q;
        bsy_cnt_d    = bsy_cnt_q;
        mc_timeout_d = 1'b0;
        mc_hold      = 1'b0;
        case (state_q)
            IDLE: begin
                if (mc_start_e && !mc_done) begin
                    mc_hold   = 1'b1;
                    state_d   = BUSY;
                    bsy_cnt_d = '0;
                end
            end
            BUSY: begin
                bsy_cnt_d = bsy_cnt_q + BSY_W'(1);
                if (mc_done) begin
                    state_d = IDLE;
                end else if (bsy_cnt_q == BSY_LAST) begin
                    state_d      = IDLE;
                    mc_timeout_d = 1'b1;
                end else begin
                    mc_hold = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Forwarding selects and load-use detection. The memory stage holds the
    // younger result, so it is checked first; register x0 is hardwired to
    // zero and must never be forwarded.
    always_comb begin
        fwd_rs1 = 2'b00;
        fwd_rs2 = 2'b00;
        if (rd_write_m && (rd_m != 5'd0) && (rd_m == rs1_e)) begin
            fwd_rs1 = 2'b10;
        end else if (rd_write_w && (rd_w != 5'd0) && (rd_w == rs1_e)) begin
            fwd_rs1 = 2'b01;
        end
        if (rd_write_m && (rd_m != 5'd0) && (rd_m == rs2_e)) begin
            fwd_rs2 = 2'b10;
        end else if (rd_write_w && (rd_w != 5'd0) && (rd_w == rs2_e)) begin
            fwd_rs2 = 2'b01;
        end
        load_use = rd_write_e && (rd_write_src_e == RD_SRC_MEM) &&
                   (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    end

    // Pipeline control outputs. A multi-cycle hold outranks everything; a
    // redirect squashes the decode instruction, so a load-use hazard against
    // it is moot and only the execute bubble remains. Reset forces every
    // control to its quiet value.
    always_comb begin
        forwarding_rs1_e = 2'b00;
        forwarding_rs2_e = 2'b00;
        stall_f          = 1'b0;
        stall_d          = 1'b0;
        stall_e          = 1'b0;
        flush_d          = 1'b0;
        flush_e          = 1'b0;
        if (!rst) begin
            forwarding_rs1_e = fwd_rs1;
            forwarding_rs2_e = fwd_rs2;
            stall_e          = mc_hold;
            stall_f          = mc_hold || (load_use && !pc_write_e);
            stall_d          = mc_hold || (load_use && !pc_write_e);
            flush_e          = !mc_hold && (pc_write_e || load_use);
            flush_d          = !mc_hold && pc_write_e;
        end
    end

    // Stall performance counter, wrapping naturally at 2^CNT_W.
    always_comb begin
        stall_cycles_d = stall_cycles_q + CNT_W'(stall_f);
    end

    // State registers. Reset mid-BUSY simply returns to IDLE without
    // raising a timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            bsy_cnt_q      <= '0;
            mc_timeout_q   <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            bsy_cnt_q      <= bsy_cnt_d;
            mc_timeout_q   <= mc_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mc_busy      = (state_q == BUSY);
    assign mc_timeout   = mc_timeout_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. A behavioural model tracks the
// multi-cycle op as "cycles elapsed since issue" and derives every expected
// output from the hazard rules each cycle. Directed scenarios come first,
// followed by a randomized run with occasional resets.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int T     = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic             rd_write_e, rd_write_m, rd_write_w;
    logic [1:0]       rd_write_src_e;
    logic             pc_write_e, mc_start_e, mc_done;
    logic [1:0]       forwarding_rs1_e, forwarding_rs2_e;
    logic             stall_f, stall_d, stall_e, flush_d, flush_e;
    logic             mc_busy, mc_timeout;
    logic [CNT_W-1:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    // Model state (values visible during the current cycle)
    bit m_busy, m_tmo;
    int m_elapsed, m_cnt;
    // Model state for the next cycle, computed before the edge
    bit n_busy, n_tmo;
    int n_elapsed, n_cnt;

    hazard_ctrl #(
        .RD_SRC_MEM (2'b01),
        .MC_TIMEOUT (T),
        .CNT_W      (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rs1_d            (rs1_d),
        .rs2_d            (rs2_d),
        .rs1_e            (rs1_e),
        .rs2_e            (rs2_e),
        .rd_e             (rd_e),
        .rd_write_e       (rd_write_e),
        .rd_write_src_e   (rd_write_src_e),
        .pc_write_e       (pc_write_e),
        .mc_start_e       (mc_start_e),
        .mc_done          (mc_done),
        .rd_m             (rd_m),
        .rd_w             (rd_w),
        .rd_write_m       (rd_write_m),
        .rd_write_w       (rd_write_w),
        .forwarding_rs1_e (forwarding_rs1_e),
        .forwarding_rs2_e (forwarding_rs2_e),
        .stall_f          (stall_f),
        .stall_d          (stall_d),
        .stall_e          (stall_e),
        .flush_d          (flush_d),
        .flush_e          (flush_e),
        .mc_busy          (mc_busy),
        .mc_timeout       (mc_timeout),
        .stall_cycles     (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rd_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (rd_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idleInputs();
        rst = 0; rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0;
        rd_m = 0; rd_w = 0; rd_write_e = 0; rd_write_m = 0; rd_write_w = 0;
        rd_write_src_e = 2'b00; pc_write_e = 0; mc_start_e = 0; mc_done = 0;
    endtask

    task automatic checkOutput();
        bit hold, lu, e_sf, e_fe, e_fd;
        logic [1:0] e_f1, e_f2;
        hold = 0; lu = 0; e_sf = 0; e_fe = 0; e_fd = 0; e_f1 = 0; e_f2 = 0;
        if (rst) begin
            n_busy = 0; n_tmo = 0; n_elapsed = 0; n_cnt = 0;
        end else begin
            n_tmo = 0;
            if (!m_busy) begin
                hold      = mc_start_e && !mc_done;
                n_busy    = hold;
                n_elapsed = 1;
            end else begin
                // Held until done, or until T cycles after issue have passed
                hold      = !(mc_done || m_elapsed >= T);
                n_tmo     = !mc_done && m_elapsed >= T;
                n_busy    = hold;
                n_elapsed = m_elapsed + 1;
            end
            lu = rd_write_e && rd_write_src_e == 2'b01 && rd_e != 0 &&
                 (rd_e == rs1_d || rd_e == rs2_d);
            e_sf  = hold || (lu && !pc_write_e);
            e_fe  = !hold && (pc_write_e || lu);
            e_fd  = !hold && pc_write_e;
            e_f1  = ref_fwd(rs1_e);
            e_f2  = ref_fwd(rs2_e);
            n_cnt = (m_cnt + int'(e_sf)) % (1 << CNT_W);
        end
        cmp("fwd_rs1",      32'(forwarding_rs1_e), 32'(e_f1));
        cmp("fwd_rs2",      32'(forwarding_rs2_e), 32'(e_f2));
        cmp("stall_f",      32'(stall_f),  32'(e_sf));
        cmp("stall_d",      32'(stall_d),  32'(e_sf));
        cmp("stall_e",      32'(stall_e),  32'(hold));
        cmp("flush_d",      32'(flush_d),  32'(e_fd));
        cmp("flush_e",      32'(flush_e),  32'(e_fe));
        cmp("mc_busy",      32'(mc_busy),  32'(m_busy));
        cmp("mc_timeout",   32'(mc_timeout), 32'(m_tmo));
        cmp("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
    endtask

    // One cycle: check at the falling edge, then clock and advance the model.
    task automatic applyStimulus();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        m_busy = n_busy; m_tmo = n_tmo; m_elapsed = n_elapsed; m_cnt = n_cnt;
        #1;
    endtask

    initial begin
        idleInputs();
        rst = 1;
        @(posedge clk);
        #1;
        m_busy = 0; m_tmo = 0; m_elapsed = 0; m_cnt = 0;

        // Reset held with hazards present: everything quiet
        rd_write_m = 1; rd_m = 3; rs1_e = 3; pc_write_e = 1; mc_start_e = 1;
        #1;
        cmp("rst_fwd",   32'(forwarding_rs1_e), 32'd0);
        cmp("rst_flush", 32'(flush_d), 32'd0);
        applyStimulus();
        idleInputs();

        // Forwarding: memory stage beats writeback
        rd_m = 5; rs1_e = 5; rd_write_m = 1; rd_w = 5; rd_write_w = 1;
        #1;
        cmp("fwd_mem_prio", 32'(forwarding_rs1_e), 32'd2);
        applyStimulus();
        // x0 is never forwarded
        rd_m = 0; rs1_e = 0; rd_w = 0;
        #1;
        cmp("fwd_x0", 32'(forwarding_rs1_e), 32'd0);
        applyStimulus();
        // Writeback forwarding on rs2
        rd_write_m = 0; rd_w = 9; rs2_e = 9;
        #1;
        cmp("fwd_wb_rs2", 32'(forwarding_rs2_e), 32'd1);
        applyStimulus();
        idleInputs();

        // Load-use against rs2_d
        rd_e = 7; rd_write_src_e = 2'b01; rd_write_e = 1; rs2_d = 7;
        #1;
        cmp("lu_stall_f", 32'(stall_f), 32'd1);
        cmp("lu_flush_e", 32'(flush_e), 32'd1);
        applyStimulus();
        idleInputs();
        applyStimulus();

        // Branch and load-use together: flush wins, no stall
        rd_e = 7; rd_write_src_e = 2'b01; rd_write_e = 1; rs1_d = 7; pc_write_e = 1;
        #1;
        cmp("br_lu_flush_d", 32'(flush_d), 32'd1);
        cmp("br_lu_flush_e", 32'(flush_e), 32'd1);
        cmp("br_lu_stall_f", 32'(stall_f), 32'd0);
        applyStimulus();
        idleInputs();

        // Multi-cycle op completing with done at cycle 4
        for (int i = 0; i < 6; i++) begin
            mc_start_e = (i <= 4);
            mc_done    = (i == 4);
            #1;
            cmp("mc_stall_e", 32'(stall_e), 32'(i < 4));
            if (i == 5) cmp("mc_idle_after", 32'(mc_busy), 32'd0);
            applyStimulus();
        end
        idleInputs();

        // Multi-cycle op that never completes: forced release at cycle 4
        for (int i = 0; i < 6; i++) begin
            mc_start_e = (i <= 4);
            #1;
            cmp("tmo_stall_e", 32'(stall_e), 32'(i < 4));
            if (i == 5) cmp("tmo_pulse", 32'(mc_timeout), 32'd1);
            applyStimulus();
        end
        idleInputs();

        // Reset while BUSY
        mc_start_e = 1;
        applyStimulus();
        applyStimulus();
        rst = 1;
        #1;
        cmp("rstbusy_stall_e", 32'(stall_e), 32'd0);
        applyStimulus();
        rst = 0; mc_start_e = 0;
        #1;
        cmp("rstbusy_idle",  32'(mc_busy), 32'd0);
        cmp("rstbusy_count", 32'(stall_cycles), 32'd0);
        cmp("rstbusy_tmo",   32'(mc_timeout), 32'd0);
        applyStimulus();

        // Randomized run
        for (int i = 0; i < 800; i++) begin
            rst            = ($urandom_range(0, 59) == 0);
            rs1_d          = 5'($urandom_range(0, 3));
            rs2_d          = 5'($urandom_range(0, 3));
            rs1_e          = 5'($urandom_range(0, 3));
            rs2_e          = 5'($urandom_range(0, 3));
            rd_e           = 5'($urandom_range(0, 3));
            rd_m           = 5'($urandom_range(0, 3));
            rd_w           = 5'($urandom_range(0, 3));
            rd_write_e     = 1'($urandom_range(0, 1));
            rd_write_m     = 1'($urandom_range(0, 1));
            rd_write_w     = 1'($urandom_range(0, 1));
            rd_write_src_e = 2'($urandom_range(0, 3));
            pc_write_e     = ($urandom_range(0, 5) == 0);
            mc_start_e     = ($urandom_range(0, 3) == 0);
            mc_done        = ($urandom_range(0, 6) == 0);
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
